// File: rtl/sha512_msg_padder.sv
// ============================================================================
// sha512_msg_padder : FIPS 180-4 padding and 1024-bit block assembly for SHA512
// Revision 1.0
// ============================================================================
`default_nettype none

module sha512_msg_padder #(
  parameter int CNT_W = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [63:0]   msg_sig,
  input  logic [3:0]    msg_bytes,
  input  logic          msg_last,
  input  logic          msg_sync,
  output logic          msg_notify,
  output logic [1023:0] blk_sig,
  output logic          blk_first,
  output logic          blk_last,
  output logic          blk_sync,
  input  logic          blk_notify
);

  localparam logic [63:0] PAD_MSB = 64'h8000_0000_0000_0000;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EMIT   = 2'd1,
    EMIT_X = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       idx;
  logic [CNT_W-1:0] count;
  logic             first_pend;
  logic             extra_pend;
  logic             extra_pad;

  logic [3:0]       n;
  logic [6:0]       sh;
  logic [63:0]      last_word;
  logic [4:0]       p;
  logic [9:0]       base_idx;
  logic [9:0]       base_p;
  logic [CNT_W-1:0] count_nxt;
  logic [127:0]     len_nxt;
  logic [127:0]     len_cur;
  logic [1023:0]    blk_word;
  logic [1023:0]    blk_x;

  // blk_sig doubles as the fill buffer; slot k lives at bits {~k,6'h3F} downto 64 below
  always_comb begin
    n         = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
    sh        = {n, 3'b000};
    last_word = (msg_sig & ~({64{1'b1}} >> sh)) | (PAD_MSB >> sh);
    p         = (n == 4'd8) ? ({1'b0, idx} + 5'd1) : {1'b0, idx};
    base_idx  = {~idx, 6'h3F};
    base_p    = {~p[3:0], 6'h3F};
    count_nxt = count + (msg_last ? CNT_W'(n) : CNT_W'(8));
    len_nxt   = 128'({count_nxt, 3'b000});
    len_cur   = 128'({count, 3'b000});

    blk_word  = blk_sig;
    blk_word[base_idx -: 64] = msg_last ? last_word : msg_sig;
    if (msg_last && (n == 4'd8) && !p[4])
      blk_word[base_p -: 64] = PAD_MSB;
    if (msg_last && (p <= 5'd13))
      blk_word[127:0] = len_nxt;

    blk_x            = '0;
    blk_x[1023:960]  = extra_pad ? PAD_MSB : 64'd0;
    blk_x[127:0]     = len_cur;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= FILL;
      idx        <= 4'd0;
      count      <= '0;
      first_pend <= 1'b1;
      extra_pend <= 1'b0;
      extra_pad  <= 1'b0;
      blk_sig    <= '0;
      blk_sync   <= 1'b0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
      msg_notify <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          msg_notify <= 1'b1;
          if (msg_sync && msg_notify) begin
            blk_sig <= blk_word;
            count   <= count_nxt;
            if (!msg_last && (idx != 4'd15)) begin
              idx <= idx + 4'd1;
            end else begin
              state      <= EMIT;
              msg_notify <= 1'b0;
              blk_sync   <= 1'b1;
              blk_first  <= first_pend;
              blk_last   <= msg_last && (p <= 5'd13);
              extra_pend <= msg_last && (p > 5'd13);
              extra_pad  <= msg_last && p[4];
            end
          end
        end

        EMIT: begin
          if (blk_notify) begin
            first_pend <= 1'b0;
            if (extra_pend) begin
              state     <= EMIT_X;
              blk_sig   <= blk_x;
              blk_first <= 1'b0;
              blk_last  <= 1'b1;
            end else begin
              state      <= FILL;
              blk_sync   <= 1'b0;
              blk_sig    <= '0;
              blk_first  <= 1'b0;
              blk_last   <= 1'b0;
              idx        <= 4'd0;
              msg_notify <= 1'b1;
              if (blk_last) begin
                count      <= '0;
                first_pend <= 1'b1;
              end
            end
          end
        end

        EMIT_X: begin
          if (blk_notify) begin
            state      <= FILL;
            blk_sync   <= 1'b0;
            blk_sig    <= '0;
            blk_first  <= 1'b0;
            blk_last   <= 1'b0;
            idx        <= 4'd0;
            count      <= '0;
            first_pend <= 1'b1;
            extra_pend <= 1'b0;
            extra_pad  <= 1'b0;
            msg_notify <= 1'b1;
          end
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sha512_msg_padder.sv
// ============================================================================
// tb_sha512_msg_padder : directed + random bench against a byte-level FIPS padding model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_sha512_msg_padder;

  logic          clk = 1'b0;
  logic          rst;
  logic [63:0]   msg_sig;
  logic [3:0]    msg_bytes;
  logic          msg_last;
  logic          msg_sync;
  logic          msg_notify;
  logic [1023:0] blk_sig;
  logic          blk_first;
  logic          blk_last;
  logic          blk_sync;
  logic          blk_notify;

  typedef struct {
    logic [1023:0] sig;
    logic          first;
    logic          last;
  } blk_t;

  blk_t       exp_q[$];
  blk_t       got_q[$];
  logic [7:0] msg_q[$];
  int         checks = 0;
  int         failures = 0;

  sha512_msg_padder #(.CNT_W(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .msg_sig    (msg_sig),
    .msg_bytes  (msg_bytes),
    .msg_last   (msg_last),
    .msg_sync   (msg_sync),
    .msg_notify (msg_notify),
    .blk_sig    (blk_sig),
    .blk_first  (blk_first),
    .blk_last   (blk_last),
    .blk_sync   (blk_sync),
    .blk_notify (blk_notify)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_blk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    logic [1023:0] tg, te;
    int w;
    checks++;
    assert (got === exp) else begin
      failures++;
      w = 0;
      for (int k = 0; k < 16; k++) begin
        tg = got >> (64 * (15 - k));
        te = exp >> (64 * (15 - k));
        if (tg[63:0] !== te[63:0]) begin
          w = k;
          break;
        end
      end
      tg = got >> (64 * (15 - w));
      te = exp >> (64 * (15 - w));
      $error("FAIL %s word%0d got=%h exp=%h", tag, w, tg[63:0], te[63:0]);
    end
  endtask

  // Reference: pad the byte string as FIPS 180-4 describes, then cut into 128-byte blocks
  function automatic void build_expected();
    int           len;
    int           nb;
    int           total;
    logic [7:0]   pad[$];
    logic [127:0] lenbits;
    logic [127:0] t;
    blk_t         e;
    len     = msg_q.size();
    nb      = (len + 17 + 127) / 128;
    total   = nb * 128;
    lenbits = 128'(len) << 3;
    for (int i = 0; i < total; i++)
      pad.push_back(i < len ? msg_q[i] : (i == len ? 8'h80 : 8'h00));
    for (int k = 0; k < 16; k++) begin
      t = lenbits >> (8 * k);
      pad[total - 1 - k] = t[7:0];
    end
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      e.sig = '0;
      for (int j = 0; j < 128; j++) e.sig = {e.sig[1015:0], pad[128 * b + j]};
      e.first = (b == 0);
      e.last  = (b == nb - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic run_msg(input int stall, input bit zero_tail);
    int          len, nw, wi, cyc, stall_left, v;
    bit          stalling;
    logic [63:0] w;
    blk_t        cur;
    len = msg_q.size();
    nw  = (len == 0) ? 1 : (len + 7) / 8;
    if (zero_tail && len > 0 && (len % 8) == 0) nw++;
    build_expected();
    got_q.delete();
    wi = 0; cyc = 0; stall_left = stall; stalling = 0;
    while (wi < nw || exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        checks++;
        failures++;
        $error("FAIL timeout words=%0d/%0d blocks_pending=%0d", wi, nw, exp_q.size());
        break;
      end
      if (blk_sync) begin
        if (exp_q.size() == 0) chk("extra_blk", blk_sync, 1'b0);
        else begin
          chk_blk("blk_sig", blk_sig, exp_q[0].sig);
          chk("blk_first", blk_first, exp_q[0].first);
          chk("blk_last", blk_last, exp_q[0].last);
          chk("notify_in_emit", msg_notify, 1'b0);
        end
      end
      if (stall_left > 0 && (stalling || blk_sync)) begin
        stalling = 1;
        chk("stall_sync", blk_sync, 1'b1);
        stall_left--;
        blk_notify = 1'b0;
      end else begin
        blk_notify = ($urandom_range(0, 3) != 0);
      end
      if (blk_sync && blk_notify && exp_q.size() > 0) begin
        cur.sig = blk_sig; cur.first = blk_first; cur.last = blk_last;
        got_q.push_back(cur);
        void'(exp_q.pop_front());
      end
      if (wi < nw) begin
        msg_sync = ($urandom_range(0, 4) != 0);
        v = len - 8 * wi;
        if (v > 8) v = 8;
        if (v < 0) v = 0;
        msg_last = (wi == nw - 1);
        w = '0;
        for (int b = 0; b < 8; b++)
          w = {w[55:0], (b < v) ? msg_q[8 * wi + b] : (msg_last ? 8'($urandom) : 8'h00)};
        msg_sig   = w;
        msg_bytes = msg_last ? ((v == 8) ? 4'($urandom_range(8, 15)) : 4'(v)) : 4'($urandom);
        if (msg_sync && msg_notify) wi++;
      end else begin
        msg_sync = 1'b0;
      end
    end
    @(negedge clk);
    blk_notify = 1'b0;
    msg_sync   = 1'b0;
    chk("idle_sync", blk_sync, 1'b0);
    chk("idle_notify", msg_notify, 1'b1);
  endtask

  task automatic rand_msg(input int len);
    msg_q.delete();
    for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
  endtask

  initial begin
    int acc;
    int blens[8];
    rst = 1'b1; msg_sig = '0; msg_bytes = '0; msg_last = 1'b0; msg_sync = 1'b0; blk_notify = 1'b0;
    repeat (2) @(negedge clk);
    chk_blk("rst_blk_sig", blk_sig, '0);
    chk("rst_blk_sync", blk_sync, 1'b0);
    chk("rst_blk_first", blk_first, 1'b0);
    chk("rst_blk_last", blk_last, 1'b0);
    chk("rst_msg_notify", msg_notify, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_notify", msg_notify, 1'b1);

    // "abc"
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(0, 0);
    chk("abc_nblk", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk("abc_w0", got_q[0].sig[1023:960], 64'h6162_6380_0000_0000);
      chk("abc_w15", got_q[0].sig[63:0], 64'h18);
      chk("abc_mid", got_q[0].sig[959:64], '0);
      chk("abc_fl", {got_q[0].first, got_q[0].last}, 2'b11);
    end

    // empty message
    msg_q.delete();
    run_msg(0, 0);
    chk("empty_nblk", got_q.size(), 1);
    if (got_q.size() >= 1) chk_blk("empty_blk", got_q[0].sig, {64'h8000_0000_0000_0000, 960'd0});

    // 112 bytes -> padding spills into a length-only block
    rand_msg(112);
    run_msg(0, 0);
    chk("m112_nblk", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("m112_b1w14", got_q[0].sig[127:64], 64'h8000_0000_0000_0000);
      chk("m112_b1w15", got_q[0].sig[63:0], 64'h0);
      chk("m112_b1fl", {got_q[0].first, got_q[0].last}, 2'b10);
      chk_blk("m112_b2", got_q[1].sig, 1024'h380);
      chk("m112_b2fl", {got_q[1].first, got_q[1].last}, 2'b01);
    end

    // 128 bytes -> data block then 0x80 + length block
    rand_msg(128);
    run_msg(0, 0);
    chk("m128_nblk", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("m128_b1last", got_q[0].last, 1'b0);
      chk_blk("m128_b2", got_q[1].sig, {64'h8000_0000_0000_0000, 896'd0, 64'h400});
      chk("m128_b2last", got_q[1].last, 1'b1);
    end

    // backpressure, then two back-to-back messages
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(10, 0);
    rand_msg(20);
    run_msg(0, 0);
    if (got_q.size() >= 1) chk("b2b1_first", got_q[0].first, 1'b1);
    rand_msg(130);
    run_msg(0, 0);
    if (got_q.size() >= 1) chk("b2b2_first", got_q[0].first, 1'b1);

    // boundary lengths around the 112/128-byte edges, some with a trailing zero-byte word
    blens = '{104, 111, 119, 120, 127, 136, 8, 240};
    foreach (blens[i]) begin
      rand_msg(blens[i]);
      run_msg(0, (i % 2) == 0);
    end

    // random lengths
    for (int i = 0; i < 16; i++) begin
      rand_msg($urandom_range(0, 300));
      run_msg(0, $urandom_range(0, 1) == 1);
    end

    // reset in the middle of a message
    acc = 0;
    msg_last = 1'b0;
    for (int c = 0; c < 50 && acc < 5; c++) begin
      @(negedge clk);
      msg_sig  = {$urandom, $urandom};
      msg_sync = 1'b1;
      if (msg_notify) acc++;
    end
    @(posedge clk);
    #2;
    msg_sync = 1'b0;
    rst = 1'b1;
    #1;
    chk_blk("mid_rst_blk_sig", blk_sig, '0);
    chk("mid_rst_notify", msg_notify, 1'b0);
    @(posedge clk);
    #1;
    chk("mid_rst_outs", {blk_sync, blk_first, blk_last, msg_notify}, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_release", msg_notify, 1'b1);
    msg_q = {8'h61, 8'h62, 8'h63};
    run_msg(0, 0);
    chk("rst_abc_nblk", got_q.size(), 1);
    if (got_q.size() >= 1) begin
      chk("rst_abc_w15", got_q[0].sig[63:0], 64'h18);
      chk("rst_abc_first", got_q[0].first, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
